// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte-stream requesters.
// Grants rotate only on packet boundaries, burst limit or owner-stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned N_BIT        = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*N_BIT-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ack,
  input  logic                   uart_ready,
  output logic [N_BIT-1:0]       uart_data,
  output logic                   uart_run,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy
);

  localparam int unsigned IdxW   = $clog2(N_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned HoldW  = $clog2(HOLD_TIMEOUT);

  localparam logic [IdxW-1:0]   RrInit   = IdxW'(N_REQ - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWaitLow, StWaitHigh, StHold} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rr_q, owner_q;
  logic                last_q;
  logic [BurstW-1:0]   burst_q;
  logic [HoldW-1:0]    hold_q;
  logic [1:0]          wait_q;
  logic [N_BIT-1:0]    uart_data_q;
  logic                uart_run_q;
  logic [N_REQ-1:0]    req_ack_q, grant_q;

  logic                win_found;
  logic [IdxW-1:0]     win_idx, cand_idx;
  logic                rel_cond, do_cap, do_rel;
  logic [IdxW-1:0]     cap_idx;
  logic [N_REQ-1:0]    cap_oh;

  // Search starts one past the last owner and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_idx = IdxW'((32'(rr_q) + k) % N_REQ);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    rel_cond = last_q || (burst_q == BurstMax);
    do_cap   = 1'b0;
    do_rel   = 1'b0;
    cap_idx  = owner_q;
    unique case (state_q)
      StIdle: begin
        cap_idx = win_idx;
        do_cap  = uart_ready && win_found;
      end
      StWaitHigh: begin
        if (uart_ready) begin
          do_rel = rel_cond;
          do_cap = !rel_cond && req_valid[owner_q];
        end
      end
      StHold: begin
        do_cap = req_valid[owner_q];
        do_rel = !req_valid[owner_q] && (hold_q == HoldLast);
      end
      default: ;
    endcase
    cap_oh = N_REQ'(1) << cap_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_q        <= RrInit;
      owner_q     <= '0;
      last_q      <= 1'b0;
      burst_q     <= '0;
      hold_q      <= '0;
      wait_q      <= '0;
      uart_data_q <= '0;
      uart_run_q  <= 1'b0;
      req_ack_q   <= '0;
      grant_q     <= '0;
    end else begin
      req_ack_q  <= '0;
      uart_run_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (do_cap) state_q <= StSend;
        end
        StSend: begin
          uart_run_q <= 1'b1;
          wait_q     <= '0;
          state_q    <= StWaitLow;
        end
        StWaitLow: begin
          // A UART that never drops ready within 4 cycles is assumed to have sent the byte.
          if (!uart_ready || (wait_q == 2'd3)) state_q <= StWaitHigh;
          else                                 wait_q  <= wait_q + 2'd1;
        end
        StWaitHigh: begin
          if (do_cap) begin
            state_q <= StSend;
          end else if (do_rel) begin
            state_q <= StIdle;
          end else if (uart_ready) begin
            state_q <= StHold;
            hold_q  <= '0;
          end
        end
        StHold: begin
          if (do_cap)      state_q <= StSend;
          else if (do_rel) state_q <= StIdle;
          else             hold_q  <= hold_q + HoldW'(1);
        end
        default: state_q <= StIdle;
      endcase

      if (do_cap) begin
        owner_q     <= cap_idx;
        grant_q     <= cap_oh;
        req_ack_q   <= cap_oh;
        uart_data_q <= req_data[32'(cap_idx)*N_BIT +: N_BIT];
        last_q      <= req_last[cap_idx];
        if (state_q == StIdle)     burst_q <= BurstW'(1);
        else if (burst_q != BurstMax) burst_q <= burst_q + BurstW'(1);
      end
      if (do_rel) begin
        rr_q    <= owner_q;
        grant_q <= '0;
      end
    end
  end

  assign req_ack   = req_ack_q;
  assign uart_data = uart_data_q;
  assign uart_run  = uart_run_q;
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);

endmodule
